// File: rtl/example2_capture_fifo.sv
`default_nettype none
// ============================================================================
// example2_capture_fifo : show-ahead capture FIFO for the example2 result word,
// with sticky overflow flag and saturating drop counter.   Rev 1.0
// ============================================================================
module example2_capture_fifo #(
  parameter int WIDTH = 67,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  // Flags decode only registered occupancy, so out_ready never reaches in_ready.
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign drop = in_valid & ~in_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins: it restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

endmodule
`default_nettype wire
